bram_rd_ctrl: RTL and testbench

Access controller that drives a simple dual-port block RAM (`bram_mem`: 1-cycle registered read, write-first forwarding on same-address collision). It turns a valid/ready lookup stream into memory reads, absorbs the fixed read latency in a 2-entry response buffer so downstream backpressure never loses data, and serialises control-plane writes onto the memory write port. It sits between a lookup pipeline stage and its table memory.

---
 rtl/bram_rd_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_bram_rd_ctrl.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_rd_ctrl.sv
// bram_rd_ctrl: lookup read controller and control-plane write serialiser for
// a simple dual-port block RAM with a 1-cycle registered read.
// Optional feature macro: BRAM_RD_CTRL_INIT_CLEAR_EN (zero-fill sweep after reset).
module bram_rd_ctrl #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 64
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  REQ_VALID,
   output logic                  REQ_READY,
   input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
   output logic                  RSP_VALID,
   input  logic                  RSP_READY,
   output logic [DATA_WIDTH-1:0] RSP_DATA,
   input  logic                  WR_REQ,
   input  logic [ADDR_WIDTH-1:0] WR_ADDR,
   input  logic [DATA_WIDTH-1:0] WR_DATA,
   output logic                  WR_ACK,
   output logic                  INIT_DONE,
   output logic                  MEM_WR,
   output logic [ADDR_WIDTH-1:0] MEM_ADDR_WR,
   output logic [DATA_WIDTH-1:0] MEM_DIN,
   output logic                  MEM_RD,
   output logic [ADDR_WIDTH-1:0] MEM_ADDR_RD,
   input  logic [DATA_WIDTH-1:0] MEM_DOUT
);

   logic                  init_done;
   logic                  sweep_wr;
   logic [ADDR_WIDTH-1:0] sweep_addr;

`ifdef BRAM_RD_CTRL_INIT_CLEAR_EN
   typedef enum logic {M_INIT, M_RUN} main_state_t;

   main_state_t         main_state, main_state_nxt;
   logic [ADDR_WIDTH:0] clr_cnt, clr_cnt_nxt;

   // Main state and clear-sweep counter registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         main_state <= M_INIT;
         clr_cnt    <= '0;
      end else begin
         main_state <= main_state_nxt;
         clr_cnt    <= clr_cnt_nxt;
      end
   end

   // Sweep one address per cycle; the counter's extra top bit marks full coverage
   always_comb begin
      main_state_nxt = main_state;
      clr_cnt_nxt    = clr_cnt;
      sweep_wr       = 1'b0;
      case (main_state)
         M_INIT: begin
            if (clr_cnt[ADDR_WIDTH]) begin
               main_state_nxt = M_RUN;
            end else begin
               sweep_wr    = 1'b1;
               clr_cnt_nxt = clr_cnt + 1'b1;
            end
         end
         M_RUN:   ;
         default: main_state_nxt = M_INIT;
      endcase
   end

   assign sweep_addr = clr_cnt[ADDR_WIDTH-1:0];
   assign init_done  = (main_state == M_RUN);
`else
   // Without the sweep, traffic is accepted from the first edge after reset
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) init_done <= 1'b0;
      else     init_done <= 1'b1;
   end

   assign sweep_wr   = 1'b0;
   assign sweep_addr = '0;
`endif

   assign INIT_DONE = init_done;

   // ---------------------------------------------------------------- write path
   typedef enum logic {W_IDLE, W_ACK} wr_state_t;

   wr_state_t wr_state, wr_state_nxt;
   logic      wr_accept;

   // Write FSM state register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) wr_state <= W_IDLE;
      else     wr_state <= wr_state_nxt;
   end

   // Accept a write only from idle; the ack cycle never accepts
   always_comb begin
      wr_state_nxt = wr_state;
      wr_accept    = 1'b0;
      case (wr_state)
         W_IDLE: begin
            if (WR_REQ && init_done) begin
               wr_accept    = 1'b1;
               wr_state_nxt = W_ACK;
            end
         end
         W_ACK:   wr_state_nxt = W_IDLE;
         default: wr_state_nxt = W_IDLE;
      endcase
   end

   assign WR_ACK = (wr_state == W_ACK);

   // Memory write port: sweep writes and accepted control-plane writes share one register stage
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         MEM_WR      <= 1'b0;
         MEM_ADDR_WR <= '0;
         MEM_DIN     <= '0;
      end else if (sweep_wr) begin
         MEM_WR      <= 1'b1;
         MEM_ADDR_WR <= sweep_addr;
         MEM_DIN     <= '0;
      end else if (wr_accept) begin
         MEM_WR      <= 1'b1;
         MEM_ADDR_WR <= WR_ADDR;
         MEM_DIN     <= WR_DATA;
      end else begin
         MEM_WR      <= 1'b0;
      end
   end

   // ----------------------------------------------------------------- read path
   logic [1:0]            occ;
   logic                  inflight;
   logic [DATA_WIDTH-1:0] fifo_mem [2];
   logic                  wr_ptr, rd_ptr;
   logic                  push, pop;
   logic [2:0]            occ_after;

   assign RSP_VALID = (occ != 2'd0);
   assign RSP_DATA  = fifo_mem[rd_ptr];
   assign pop       = RSP_VALID & RSP_READY;
   assign push      = inflight;

   // Count the in-flight read as occupied so its data always has a slot when it lands
   assign occ_after = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
   assign REQ_READY = init_done & (occ_after < 3'd2);

   assign MEM_RD      = REQ_VALID & REQ_READY;
   assign MEM_ADDR_RD = REQ_ADDR;

   // In-flight flag marks MEM_DOUT valid one cycle after a read is issued
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) inflight <= 1'b0;
      else     inflight <= MEM_RD;
   end

   // Two-entry response FIFO
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int unsigned i = 0; i < 2; i++) fifo_mem[i] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         occ    <= 2'd0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= MEM_DOUT;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

endmodule

// File: tb/tb_bram_rd_ctrl.sv
// tb_bram_rd_ctrl: self-checking bench for bram_rd_ctrl with a behavioural
// write-first block RAM attached and a reference model of memory contents and
// response ordering/timing.
module tb_bram_rd_ctrl;

   localparam int AW    = 4;
   localparam int DW    = 32;
   localparam int DEPTH = 16;
`ifdef BRAM_RD_CTRL_INIT_CLEAR_EN
   localparam int EXP_INIT_EDGES = DEPTH + 1;
`else
   localparam int EXP_INIT_EDGES = 1;
`endif

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          REQ_VALID = 1'b0;
   logic          REQ_READY;
   logic [AW-1:0] REQ_ADDR = '0;
   logic          RSP_VALID;
   logic          RSP_READY = 1'b0;
   logic [DW-1:0] RSP_DATA;
   logic          WR_REQ = 1'b0;
   logic [AW-1:0] WR_ADDR = '0;
   logic [DW-1:0] WR_DATA = '0;
   logic          WR_ACK;
   logic          INIT_DONE;
   logic          MEM_WR;
   logic [AW-1:0] MEM_ADDR_WR;
   logic [DW-1:0] MEM_DIN;
   logic          MEM_RD;
   logic [AW-1:0] MEM_ADDR_RD;
   logic [DW-1:0] MEM_DOUT;

   bram_rd_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .CLK(CLK), .RST(RST),
      .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ADDR(REQ_ADDR),
      .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
      .WR_REQ(WR_REQ), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_ACK(WR_ACK),
      .INIT_DONE(INIT_DONE),
      .MEM_WR(MEM_WR), .MEM_ADDR_WR(MEM_ADDR_WR), .MEM_DIN(MEM_DIN),
      .MEM_RD(MEM_RD), .MEM_ADDR_RD(MEM_ADDR_RD), .MEM_DOUT(MEM_DOUT)
   );

   always #5 CLK = ~CLK;

   // Attached block RAM: registered read, write-first on same-address collision
   logic [DW-1:0] bram      [DEPTH];
   logic [DW-1:0] init_vals [DEPTH];
   logic          env_loaded = 1'b0;

   always @(posedge CLK) begin
      if (!env_loaded) begin
         for (int i = 0; i < DEPTH; i++) bram[i] <= init_vals[i];
         env_loaded <= 1'b1;
      end else if (MEM_WR) begin
         bram[MEM_ADDR_WR] <= MEM_DIN;
      end
      if (MEM_RD) MEM_DOUT <= (MEM_WR && MEM_ADDR_WR == MEM_ADDR_RD) ? MEM_DIN : bram[MEM_ADDR_RD];
   end

   // Reference model state
   int            total = 0;
   int            bad   = 0;
   int            cyc   = 0;
   logic [DW-1:0] ref_mem [DEPTH];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] got_q[$];
   int            acc_cyc_q[$];
   int            pop_cyc_q[$];

   // Values sampled mid-cycle by step()
   logic          s_req_ready, s_rsp_valid, s_ack, s_acc, s_pop, s_mem_wr, s_init_done;
   logic [DW-1:0] s_rsp_data, s_mem_din;
   logic [AW-1:0] s_mem_addr_wr;

   task automatic clear_model();
      exp_q.delete();
      got_q.delete();
      acc_cyc_q.delete();
      pop_cyc_q.delete();
   endtask

   // One clock cycle: sample at the falling edge, update the model, return 1 time unit after the rising edge
   task automatic step();
      @(negedge CLK);
      s_req_ready   = REQ_READY;
      s_rsp_valid   = RSP_VALID;
      s_rsp_data    = RSP_DATA;
      s_ack         = WR_ACK;
      s_mem_wr      = MEM_WR;
      s_mem_addr_wr = MEM_ADDR_WR;
      s_mem_din     = MEM_DIN;
      s_init_done   = INIT_DONE;
      s_acc         = REQ_VALID && REQ_READY;
      s_pop         = RSP_VALID && RSP_READY;
      // A committed write is visible to a read accepted in the same cycle
      if (s_ack) ref_mem[WR_ADDR] = WR_DATA;
      if (s_acc) begin
         exp_q.push_back(ref_mem[REQ_ADDR]);
         acc_cyc_q.push_back(cyc);
      end
      if (s_pop) begin
         got_q.push_back(RSP_DATA);
         pop_cyc_q.push_back(cyc);
         if (acc_cyc_q.size() > 0) void'(acc_cyc_q.pop_front());
      end
      @(posedge CLK);
      #1;
      cyc++;
      if (s_ack) WR_REQ = 1'b0;
   endtask

   task automatic release_reset();
      int n;
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      n = 0;
      while (INIT_DONE !== 1'b1 && n < 100) begin
         @(posedge CLK);
         #1;
         n++;
         cyc++;
      end
`ifdef BRAM_RD_CTRL_INIT_CLEAR_EN
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`endif
   endtask

   task automatic test_reset();
      int n, early_bad, sweep_bad;
      REQ_VALID = 1'b1;
      WR_REQ    = 1'b1;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      total++; if (REQ_READY !== 1'b0)  begin bad++; $display("FAIL rst_req_ready: got %b want 0", REQ_READY); end
      total++; if (RSP_VALID !== 1'b0)  begin bad++; $display("FAIL rst_rsp_valid: got %b want 0", RSP_VALID); end
      total++; if (RSP_DATA !== '0)     begin bad++; $display("FAIL rst_rsp_data: got %h want 0", RSP_DATA); end
      total++; if (WR_ACK !== 1'b0)     begin bad++; $display("FAIL rst_wr_ack: got %b want 0", WR_ACK); end
      total++; if (INIT_DONE !== 1'b0)  begin bad++; $display("FAIL rst_init_done: got %b want 0", INIT_DONE); end
      total++; if (MEM_WR !== 1'b0)     begin bad++; $display("FAIL rst_mem_wr: got %b want 0", MEM_WR); end
      total++; if (MEM_RD !== 1'b0)     begin bad++; $display("FAIL rst_mem_rd: got %b want 0", MEM_RD); end
      total++; if (MEM_ADDR_WR !== '0)  begin bad++; $display("FAIL rst_mem_addr_wr: got %h want 0", MEM_ADDR_WR); end
      total++; if (MEM_DIN !== '0)      begin bad++; $display("FAIL rst_mem_din: got %h want 0", MEM_DIN); end
      @(posedge CLK);
      #1;
      REQ_VALID = 1'b0;
      WR_REQ    = 1'b0;
      RST       = 1'b0;
      n = 0; early_bad = 0; sweep_bad = 0;
      while (INIT_DONE !== 1'b1 && n < 100) begin
         @(posedge CLK);
         #1;
         n++;
         cyc++;
`ifdef BRAM_RD_CTRL_INIT_CLEAR_EN
         if (n <= DEPTH && (MEM_WR !== 1'b1 || MEM_ADDR_WR !== AW'(n - 1) || MEM_DIN !== '0)) sweep_bad++;
`endif
         if (INIT_DONE !== 1'b1 && REQ_READY !== 1'b0) early_bad++;
      end
      total++; if (n != EXP_INIT_EDGES) begin bad++; $display("FAIL init_done_delay: got %0d edges want %0d", n, EXP_INIT_EDGES); end
      total++; if (early_bad != 0) begin bad++; $display("FAIL ready_before_init: got %0d cycles want 0", early_bad); end
`ifdef BRAM_RD_CTRL_INIT_CLEAR_EN
      total++; if (sweep_bad != 0) begin bad++; $display("FAIL sweep_writes: got %0d bad cycles want 0", sweep_bad); end
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`endif
   endtask

`ifdef BRAM_RD_CTRL_INIT_CLEAR_EN
   task automatic test_init_clear();
      clear_model();
      RSP_READY = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         REQ_VALID = 1'b1;
         REQ_ADDR  = AW'(i);
         step();
      end
      REQ_VALID = 1'b0;
      repeat (4) step();
      total++; if (got_q.size() != DEPTH) begin bad++; $display("FAIL clear_count: got %0d want %0d", got_q.size(), DEPTH); end
      for (int i = 0; i < got_q.size(); i++) begin
         total++; if (got_q[i] !== '0) begin bad++; $display("FAIL clear_data[%0d]: got %h want 0", i, got_q[i]); end
      end
   endtask
`endif

   task automatic test_write_read();
      clear_model();
      RSP_READY = 1'b1;
      WR_ADDR   = 4'd3;
      WR_DATA   = 32'hDEADBEEF;
      WR_REQ    = 1'b1;
      step();
      total++; if (s_ack !== 1'b0) begin bad++; $display("FAIL wr_ack_early: got %b want 0", s_ack); end
      step();
      total++;
      if (s_ack !== 1'b1 || s_mem_wr !== 1'b1 || s_mem_addr_wr !== 4'd3 || s_mem_din !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL wr_commit: got ack=%b wr=%b addr=%h din=%h want ack=1 wr=1 addr=3 din=deadbeef",
                  s_ack, s_mem_wr, s_mem_addr_wr, s_mem_din);
      end
      step();
      total++; if (s_ack !== 1'b0 || s_mem_wr !== 1'b0) begin bad++; $display("FAIL wr_ack_pulse: got ack=%b wr=%b want 0 0", s_ack, s_mem_wr); end
      REQ_VALID = 1'b1;
      REQ_ADDR  = 4'd3;
      step();
      total++; if (s_acc !== 1'b1) begin bad++; $display("FAIL rd_accept: got %b want 1", s_acc); end
      REQ_VALID = 1'b0;
      step();
      total++; if (s_rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_latency_early: got %b want 0", s_rsp_valid); end
      step();
      total++;
      if (s_rsp_valid !== 1'b1 || s_rsp_data !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL rd_data: got valid=%b data=%h want 1 deadbeef", s_rsp_valid, s_rsp_data);
      end
   endtask

   task automatic test_back_to_back();
      int low, start;
      clear_model();
      RSP_READY = 1'b1;
      low   = 0;
      start = cyc;
      for (int i = 0; i < 8; i++) begin
         REQ_VALID = 1'b1;
         REQ_ADDR  = AW'(i);
         step();
         if (s_req_ready !== 1'b1) low++;
      end
      REQ_VALID = 1'b0;
      repeat (4) step();
      total++; if (low != 0) begin bad++; $display("FAIL b2b_ready_low: got %0d cycles want 0", low); end
      total++; if (got_q.size() != 8) begin bad++; $display("FAIL b2b_count: got %0d want 8", got_q.size()); end
      if (got_q.size() == 8 && exp_q.size() == 8) begin
         total++; if (pop_cyc_q[0] != start + 2) begin bad++; $display("FAIL b2b_first_latency: got cycle %0d want %0d", pop_cyc_q[0], start + 2); end
         for (int i = 0; i < 8; i++) begin
            total++;
            if (got_q[i] !== exp_q[i] || pop_cyc_q[i] != pop_cyc_q[0] + i) begin
               bad++;
               $display("FAIL b2b_rsp[%0d]: got %h at cycle %0d want %h at cycle %0d",
                        i, got_q[i], pop_cyc_q[i], exp_q[i], pop_cyc_q[0] + i);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int acc, n;
      clear_model();
      RSP_READY = 1'b0;
      REQ_VALID = 1'b1;
      REQ_ADDR  = AW'($urandom_range(DEPTH - 1));
      acc = 0;
      repeat (6) begin
         step();
         if (s_acc) begin
            acc++;
            REQ_ADDR = AW'($urandom_range(DEPTH - 1));
         end
      end
      total++; if (acc != 2) begin bad++; $display("FAIL bp_accepts: got %0d want 2", acc); end
      total++; if (s_req_ready !== 1'b0) begin bad++; $display("FAIL bp_stall: got %b want 0", s_req_ready); end
      REQ_VALID = 1'b0;
      RSP_READY = 1'b1;
      n = 0;
      while (got_q.size() < 2 && n < 10) begin
         step();
         n++;
      end
      total++; if (got_q.size() != 2) begin bad++; $display("FAIL bp_drain: got %0d responses want 2", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      step();
      total++; if (s_rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_dup: got %b want 0", s_rsp_valid); end
   endtask

   task automatic test_collision();
      clear_model();
      RSP_READY = 1'b1;
      WR_ADDR   = 4'd5;
      WR_DATA   = 32'h12345678;
      WR_REQ    = 1'b1;
      step();
      REQ_VALID = 1'b1;
      REQ_ADDR  = 4'd5;
      step();
      total++; if (s_ack !== 1'b1 || s_acc !== 1'b1) begin bad++; $display("FAIL coll_align: got ack=%b acc=%b want 1 1", s_ack, s_acc); end
      REQ_VALID = 1'b0;
      step();
      step();
      total++;
      if (s_rsp_valid !== 1'b1 || s_rsp_data !== 32'h12345678) begin
         bad++;
         $display("FAIL coll_data: got valid=%b data=%h want 1 12345678", s_rsp_valid, s_rsp_data);
      end
   endtask

   task automatic test_random();
      int   wr_age, n, outstanding, popn;
      logic exp_valid, exp_ready, was_wr;
      clear_model();
      wr_age    = 0;
      REQ_VALID = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!WR_REQ && $urandom_range(5) == 0) begin
            WR_ADDR = AW'($urandom_range(DEPTH - 1));
            WR_DATA = $urandom;
            WR_REQ  = 1'b1;
            wr_age  = 0;
         end
         if (!REQ_VALID) begin
            REQ_VALID = ($urandom_range(3) != 0);
            REQ_ADDR  = AW'($urandom_range(DEPTH - 1));
         end
         RSP_READY   = ($urandom_range(2) != 0);
         outstanding = acc_cyc_q.size();
         exp_valid   = (outstanding > 0) && (acc_cyc_q[0] + 2 <= cyc);
         popn        = (exp_valid && RSP_READY) ? 1 : 0;
         exp_ready   = (outstanding - popn) < 2;
         was_wr      = WR_REQ;
         step();
         total++; if (s_rsp_valid !== exp_valid) begin bad++; $display("FAIL rnd_rsp_valid@%0d: got %b want %b", cyc, s_rsp_valid, exp_valid); end
         total++; if (s_req_ready !== exp_ready) begin bad++; $display("FAIL rnd_req_ready@%0d: got %b want %b", cyc, s_req_ready, exp_ready); end
         if (was_wr) begin
            wr_age++;
            if (s_ack) begin
               total++; if (wr_age != 2) begin bad++; $display("FAIL rnd_wr_ack_latency: got %0d want 2", wr_age); end
            end else if (wr_age >= 2) begin
               total++; bad++;
               $display("FAIL rnd_wr_ack_missing: got no ack after %0d cycles want ack at 2", wr_age);
               WR_REQ = 1'b0;
            end
         end
         if (s_acc || !REQ_VALID) begin
            REQ_VALID = ($urandom_range(3) != 0);
            REQ_ADDR  = AW'($urandom_range(DEPTH - 1));
         end
      end
      REQ_VALID = 1'b0;
      RSP_READY = 1'b1;
      n = 0;
      while ((acc_cyc_q.size() > 0 || WR_REQ) && n < 20) begin
         step();
         n++;
      end
      WR_REQ = 1'b0;
      total++; if (acc_cyc_q.size() != 0) begin bad++; $display("FAIL rnd_drain: got %0d outstanding want 0", acc_cyc_q.size()); end
      total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rnd_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_reset_mid();
      int stale;
      clear_model();
      RSP_READY = 1'b0;
      REQ_VALID = 1'b1;
      REQ_ADDR  = AW'($urandom_range(DEPTH - 1));
      step();
      REQ_ADDR  = AW'($urandom_range(DEPTH - 1));
      step();
      total++; if (RSP_VALID !== 1'b1) begin bad++; $display("FAIL rst_mid_precond: got %b want 1", RSP_VALID); end
      WR_ADDR = AW'($urandom_range(DEPTH - 1));
      WR_DATA = $urandom;
      WR_REQ  = 1'b1;
      #1;
      RST = 1'b1;
      #1;
      total++; if (RSP_VALID !== 1'b0) begin bad++; $display("FAIL rst_mid_rsp_valid: got %b want 0", RSP_VALID); end
      total++; if (REQ_READY !== 1'b0) begin bad++; $display("FAIL rst_mid_req_ready: got %b want 0", REQ_READY); end
      REQ_VALID = 1'b0;
      WR_REQ    = 1'b0;
      clear_model();
      release_reset();
      RSP_READY = 1'b1;
      stale = 0;
      repeat (6) begin
         step();
         if (s_rsp_valid || s_ack) stale++;
      end
      total++; if (stale != 0) begin bad++; $display("FAIL rst_mid_stale: got %0d cycles want 0", stale); end
      REQ_VALID = 1'b1;
      REQ_ADDR  = AW'($urandom_range(DEPTH - 1));
      step();
      REQ_VALID = 1'b0;
      step();
      step();
      total++;
      if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin
         bad++;
         $display("FAIL rst_mid_fresh: got %0d responses want 1 matching model", got_q.size());
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         init_vals[i] = $urandom;
         ref_mem[i]   = init_vals[i];
      end
      test_reset();
`ifdef BRAM_RD_CTRL_INIT_CLEAR_EN
      test_init_clear();
`endif
      test_write_read();
      test_back_to_back();
      test_backpressure();
      test_collision();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
